// File: rtl/ysyx_24100006_axi_arb.sv
// Round-robin AXI-Lite arbiter: IFU (read-only) and LSU (read/write) share one slave port.
// One whole transaction is owned at a time; channels are muxed combinationally from the state.
module ysyx_24100006_axi_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    // IFU read master
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    // LSU read/write master
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    // slave port
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [1:0]          grant
);

    // Encoding doubles as the grant code.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IFU_RD = 2'b01,
        LSU_RD = 2'b10,
        LSU_WR = 2'b11
    } state_t;

    state_t state;
    logic   last;      // 0 = IFU served last, 1 = LSU served last

    logic ifu_req, lsu_req, lsu_wr_req, lsu_wins;
    logic sel_ifu, sel_lsu_rd, sel_wr;
    logic r_done, b_done;

    assign ifu_req    = ifu_arvalid;
    assign lsu_wr_req = lsu_awvalid | lsu_wvalid;
    assign lsu_req    = lsu_arvalid | lsu_wr_req;
    assign lsu_wins   = lsu_req & (~ifu_req | ~last);

    assign r_done = m_rvalid & m_rready;
    assign b_done = m_bvalid & m_bready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_wins)     state <= lsu_wr_req ? LSU_WR : LSU_RD;
                    else if (ifu_req) state <= IFU_RD;
                end
                IFU_RD: if (r_done) begin
                    state <= IDLE;
                    last  <= 1'b0;
                end
                LSU_RD: if (r_done) begin
                    state <= IDLE;
                    last  <= 1'b1;
                end
                LSU_WR: if (b_done) begin
                    state <= IDLE;
                    last  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant      = state;
    assign sel_ifu    = (state == IFU_RD);
    assign sel_lsu_rd = (state == LSU_RD);
    assign sel_wr     = (state == LSU_WR);

    // Read side toward the slave
    assign m_araddr  = sel_ifu ? ifu_araddr : (sel_lsu_rd ? lsu_araddr : '0);
    assign m_arvalid = (sel_ifu & ifu_arvalid) | (sel_lsu_rd & lsu_arvalid);
    assign m_rready  = (sel_ifu & ifu_rready)  | (sel_lsu_rd & lsu_rready);

    // Write side toward the slave
    assign m_awaddr  = sel_wr ? lsu_awaddr : '0;
    assign m_awvalid = sel_wr & lsu_awvalid;
    assign m_wdata   = sel_wr ? lsu_wdata : '0;
    assign m_wstrb   = sel_wr ? lsu_wstrb : '0;
    assign m_wvalid  = sel_wr & lsu_wvalid;
    assign m_bready  = sel_wr & lsu_bready;

    // Responses back to the masters; non-owners see all zeros
    assign ifu_arready = sel_ifu & m_arready;
    assign ifu_rdata   = sel_ifu ? m_rdata : '0;
    assign ifu_rresp   = sel_ifu ? m_rresp : 2'b00;
    assign ifu_rvalid  = sel_ifu & m_rvalid;

    assign lsu_arready = sel_lsu_rd & m_arready;
    assign lsu_rdata   = sel_lsu_rd ? m_rdata : '0;
    assign lsu_rresp   = sel_lsu_rd ? m_rresp : 2'b00;
    assign lsu_rvalid  = sel_lsu_rd & m_rvalid;

    assign lsu_awready = sel_wr & m_awready;
    assign lsu_wready  = sel_wr & m_wready;
    assign lsu_bresp   = sel_wr ? m_bresp : 2'b00;
    assign lsu_bvalid  = sel_wr & m_bvalid;

endmodule

// File: tb/tb_ysyx_24100006_axi_arb.sv
// Bench for the IFU/LSU AXI-Lite arbiter: behavioural slave, two master drivers,
// response scoreboards and a grant-order log.
module tb_ysyx_24100006_axi_arb;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ifu_araddr;
    logic          ifu_arvalid, ifu_arready;
    logic [DW-1:0] ifu_rdata;
    logic [1:0]    ifu_rresp;
    logic          ifu_rvalid, ifu_rready;
    logic [AW-1:0] lsu_araddr;
    logic          lsu_arvalid, lsu_arready;
    logic [DW-1:0] lsu_rdata;
    logic [1:0]    lsu_rresp;
    logic          lsu_rvalid, lsu_rready;
    logic [AW-1:0] lsu_awaddr;
    logic          lsu_awvalid, lsu_awready;
    logic [DW-1:0] lsu_wdata;
    logic [3:0]    lsu_wstrb;
    logic          lsu_wvalid, lsu_wready;
    logic [1:0]    lsu_bresp;
    logic          lsu_bvalid, lsu_bready;
    logic [AW-1:0] m_araddr;
    logic          m_arvalid, m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rvalid, m_rready;
    logic [AW-1:0] m_awaddr;
    logic          m_awvalid, m_awready;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_wvalid, m_wready;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;
    logic [1:0]    grant;

    ysyx_24100006_axi_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [33:0] ifu_q[$];   // {rresp, rdata}
    logic [33:0] lsu_q[$];
    logic [1:0]  b_q[$];
    logic [67:0] wr_q[$];    // {addr, data, strb} expected at the slave
    logic [1:0]  glog[$];

    int v_ifu = 0, v_lsu = 0, v_wr = 0, v_rd = 0, bcnt = 0;
    int rd_lat = 2, aw_lat = 0, w_lat = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : ((a ^ 32'hA5A5_0000) + 32'h11);
    endfunction

    // Behavioural slave: samples handshakes at negedge, updates outputs just after posedge
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, ar_seen, aw_seen, w_seen;
    logic        rd_busy, aw_got, w_got;
    logic [31:0] rd_addr, wa, wd;
    logic [3:0]  ws;
    logic [67:0] wexp;
    int          rd_cnt, aw_cnt, w_cnt;

    initial begin
        m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
        m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
        rd_busy = 0; aw_got = 0; w_got = 0; rd_cnt = 0; aw_cnt = 0; w_cnt = 0;
        rd_addr = 0; wa = 0; wd = 0; ws = 0;
        forever begin
            @(negedge clk);
            ar_hs = m_arvalid && m_arready;
            r_hs  = m_rvalid && m_rready;
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            b_hs  = m_bvalid && m_bready;
            ar_seen = m_arvalid; aw_seen = m_awvalid; w_seen = m_wvalid;
            if (ar_hs) rd_addr = m_araddr;
            if (aw_hs) wa = m_awaddr;
            if (w_hs) begin wd = m_wdata; ws = m_wstrb; end
            if (m_awvalid && !aw_got) aw_cnt++;
            if (m_wvalid && !w_got) w_cnt++;
            @(posedge clk); #1;
            if (reset) begin
                m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
                rd_busy = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
                continue;
            end
            if (ar_hs) begin rd_busy = 1; rd_cnt = rd_lat; end
            if (r_hs) begin
                m_rvalid = 0; m_rdata = 0; m_rresp = 0; rd_busy = 0;
            end else if (rd_busy && !m_rvalid) begin
                if (rd_cnt <= 1) begin
                    m_rvalid = 1; m_rdata = rd_fn(rd_addr); m_rresp = rd_addr[5:4];
                end else rd_cnt--;
            end
            m_arready = !rd_busy && ar_seen;
            if (aw_hs) aw_got = 1;
            if (w_hs)  w_got = 1;
            if (b_hs) begin
                m_bvalid = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
            end else if (aw_got && w_got && !m_bvalid) begin
                m_bvalid = 1; m_bresp = 2'b00;
                if (wr_q.size() == 0) chk("slv_wr_unexp", 64'd1, 64'd0);
                else begin
                    wexp = wr_q.pop_front();
                    chk("slv_awaddr", 64'(wa), 64'(wexp[67:36]));
                    chk("slv_wdata", 64'({wd, ws}), 64'(wexp[35:0]));
                end
            end
            m_awready = !aw_got && aw_seen && (aw_cnt > aw_lat);
            m_wready  = !w_got && w_seen && (w_cnt > w_lat);
        end
    end

    // Grant-order log, ownership isolation and B handshake counting
    logic [1:0] gprev = 2'b00;
    always @(negedge clk) begin
        if (grant != 2'b00 && grant != gprev) glog.push_back(grant);
        gprev = grant;
        if (grant != 2'b01 && (ifu_arready || ifu_rvalid || ifu_rdata != 0 || ifu_rresp != 0)) v_ifu++;
        if (grant != 2'b10 && (lsu_arready || lsu_rvalid || lsu_rdata != 0 || lsu_rresp != 0)) v_lsu++;
        if (grant != 2'b11 && (lsu_awready || lsu_wready || lsu_bvalid || m_awvalid || m_wvalid ||
                               m_bready || m_awaddr != 0 || m_wdata != 0 || m_wstrb != 0)) v_wr++;
        if (grant != 2'b01 && grant != 2'b10 && (m_arvalid || m_rready || m_araddr != 0)) v_rd++;
        if (lsu_bvalid && lsu_bready) bcnt++;
    end

    task automatic ifu_read(input logic [31:0] a);
        int n;
        logic [33:0] e;
        ifu_q.push_back({a[5:4], rd_fn(a)});
        ifu_araddr = a; ifu_arvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifu_arready && n < TMO);
        chk("ifu_ar_hs", 64'(ifu_arready), 64'd1);
        @(posedge clk); #1;
        ifu_arvalid = 0; ifu_araddr = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifu_rvalid && n < TMO);
        chk("ifu_r_vld", 64'(ifu_rvalid), 64'd1);
        if (ifu_rvalid) begin
            if (ifu_q.size() == 0) chk("ifu_q_empty", 64'd1, 64'd0);
            else begin e = ifu_q.pop_front(); chk("ifu_rdata", 64'({ifu_rresp, ifu_rdata}), 64'(e)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic lsu_read(input logic [31:0] a);
        int n;
        logic [33:0] e;
        lsu_q.push_back({a[5:4], rd_fn(a)});
        lsu_araddr = a; lsu_arvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu_arready && n < TMO);
        chk("lsu_ar_hs", 64'(lsu_arready), 64'd1);
        @(posedge clk); #1;
        lsu_arvalid = 0; lsu_araddr = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu_rvalid && n < TMO);
        chk("lsu_r_vld", 64'(lsu_rvalid), 64'd1);
        if (lsu_rvalid) begin
            if (lsu_q.size() == 0) chk("lsu_q_empty", 64'd1, 64'd0);
            else begin e = lsu_q.pop_front(); chk("lsu_rdata", 64'({lsu_rresp, lsu_rdata}), 64'(e)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic awh, wh;
        logic [1:0] e;
        wr_q.push_back({a, d, s});
        b_q.push_back(2'b00);
        lsu_awaddr = a; lsu_awvalid = 1; lsu_wdata = d; lsu_wstrb = s; lsu_wvalid = 1;
        n = 0;
        while ((lsu_awvalid || lsu_wvalid) && n < TMO) begin
            @(negedge clk);
            awh = lsu_awvalid && lsu_awready;
            wh  = lsu_wvalid && lsu_wready;
            @(posedge clk); #1;
            if (awh) begin lsu_awvalid = 0; lsu_awaddr = 0; end
            if (wh)  begin lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; end
            n++;
        end
        chk("lsu_aw_w_hs", 64'({lsu_awvalid, lsu_wvalid}), 64'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu_bvalid && n < TMO);
        chk("lsu_b_vld", 64'(lsu_bvalid), 64'd1);
        if (lsu_bvalid) begin
            if (b_q.size() == 0) chk("lsu_bq_empty", 64'd1, 64'd0);
            else begin e = b_q.pop_front(); chk("lsu_bresp", 64'(lsu_bresp), 64'(e)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_log(input string tag, input logic [1:0] exp[$]);
        chk({tag, "_len"}, 64'(glog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < glog.size(); i++)
            chk(tag, 64'(glog[i]), 64'(exp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1;
        ifu_araddr = 0; ifu_arvalid = 0; ifu_rready = 1;
        lsu_araddr = 0; lsu_arvalid = 0; lsu_rready = 1;
        lsu_awaddr = 0; lsu_awvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0; lsu_bready = 1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_outs", 64'(|{ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, lsu_arready, lsu_rdata,
                             lsu_rresp, lsu_rvalid, lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
                             m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb,
                             m_wvalid, m_bready}), 64'd0);
        @(posedge clk); #1; reset = 0;

        // Reset while a write is in flight: AW done, W stalled by the slave
        w_lat = 50;
        @(posedge clk); #1;
        lsu_awaddr = 32'h8000_0200; lsu_awvalid = 1; lsu_wdata = 32'hCAFE_0001; lsu_wstrb = 4'hF; lsu_wvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu_awready && n < TMO);
        chk("t1_aw_hs", 64'(lsu_awready), 64'd1);
        @(posedge clk); #1; lsu_awvalid = 0; lsu_awaddr = 0;
        @(negedge clk);
        chk("t1_pre", 64'({grant, m_wvalid, m_bready}), 64'({2'b11, 1'b1, 1'b1}));
        #2 reset = 1;
        #1;
        chk("t1_grant", 64'(grant), 64'd0);
        chk("t1_wr_vld", 64'({m_awvalid, m_wvalid, m_bready}), 64'd0);
        lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0;
        @(posedge clk); @(posedge clk); #1; reset = 0; w_lat = 0;

        // IFU alone: one-cycle arbitration, fetch data, IDLE afterwards
        @(posedge clk); #1;
        fork
            ifu_read(32'h8000_0000);
            begin
                @(negedge clk) chk("t2_g_req", 64'(grant), 64'd0);
                @(negedge clk) chk("t2_g_next", 64'(grant), 64'd1);
            end
        join
        @(negedge clk) chk("t2_idle", 64'(grant), 64'd0);

        // Contested right after reset: LSU first, then IFU
        @(posedge clk); #1; reset = 1;
        @(posedge clk); #1; reset = 0;
        glog.delete();
        fork
            ifu_read(32'h8000_0010);
            lsu_read(32'h8000_0420);
        join
        chk_log("t3_order", '{2'b10, 2'b01});

        // Continuous contention: strict alternation
        glog.delete();
        fork
            for (int i = 0; i < 3; i++) ifu_read(32'h8000_1000 + 32'(i * 16));
            for (int j = 0; j < 3; j++) lsu_read(32'h9000_0000 + 32'(j * 36));
        join
        chk_log("t4_order", '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01});

        // Write with W accepted two cycles before AW
        aw_lat = 2; w_lat = 0; bcnt = 0;
        lsu_write(32'h8000_0100, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        chk("t5_idle", 64'(grant), 64'd0);
        chk("t5_bcnt", 64'(bcnt), 64'd1);
        aw_lat = 0;

        // LSU read and write together: write first, read next
        glog.delete();
        fork
            lsu_write(32'h8000_0200, 32'h1234_5678, 4'b0101);
            lsu_read(32'h8000_0330);
        join
        chk_log("t6_order", '{2'b11, 2'b10});

        repeat (2) @(posedge clk);
        chk("iso_ifu", 64'(v_ifu), 64'd0);
        chk("iso_lsu", 64'(v_lsu), 64'd0);
        chk("iso_wr", 64'(v_wr), 64'd0);
        chk("iso_rd", 64'(v_rd), 64'd0);
        chk("sb_left", 64'(ifu_q.size() + lsu_q.size() + b_q.size() + wr_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
